goldschmidt_ctrl: RTL and testbench
===================================

# goldschmidt_ctrl

Sequencing controller for the Goldschmidt divider `datapath`. It accepts a start request and drives `load_regN`, `load_regD`, `sel_ND_mux` and `sel_K_mux` through the initial IA scaling and a fixed number of K refinement iterations. It then flags completion when the quotient on the datapath `result` output is valid. It sits between the top-level divide unit and `datapath`, replacing hand-driven bench control.

## Interface
- `NUM_ITER`, default 4: number of K·D / K·N refinement pairs after the IA pair; legal range 1–15.
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset; asserted (0) forces the idle state immediately.
- `start`  in  1  request a division; sampled only in IDLE and DONE.
- `abort`  in  1  synchronous cancel; any state returns to IDLE on the next edge.
- `busy`  out  1  high from the first sequencing cycle through the last K·N cycle.
- `done`  out  1  one-cycle pulse; datapath `result` holds the quotient during this cycle.
- `load_regN`  out  1  to datapath: capture the product into the N register.
- `load_regD`  out  1  to datapath: capture the product into the D register.
- `sel_ND_mux`  out  2  to datapath operand select: 00 = IA·D, 01 = IA·N, 10 = K·D, 11 = K·N.
- `sel_K_mux`  out  1  to datapath: 1 = use IA as multiplier, 0 = use K = 2 − D.

## Operation
- States: IDLE, INIT_D, INIT_N, ITER_D, ITER_N, DONE.
- IDLE: loads 0, `sel_ND_mux`=00, `sel_K_mux`=1, `busy`=0, `done`=0. If `start`=1, go to INIT_D.
- INIT_D: `load_regD`=1, `sel_ND_mux`=00, `sel_K_mux`=1. Go to INIT_N.
- INIT_N: `load_regN`=1, `sel_ND_mux`=01, `sel_K_mux`=1. Clear the iteration counter to 0. Go to ITER_D.
- ITER_D: `load_regD`=1, `sel_ND_mux`=10, `sel_K_mux`=0. Go to ITER_N.
- ITER_N: `load_regN`=1, `sel_ND_mux`=11, `sel_K_mux`=0. Increment the counter.
  - If counter = NUM_ITER−1 before the increment, go to DONE.
  - Otherwise go to ITER_D.
- DONE: `done`=1, loads 0, selects as in IDLE.
  - If `start`=1, go to INIT_D (back-to-back operation).
  - Otherwise go to IDLE.
- `load_regN` and `load_regD` are never high in the same cycle.
- Counter width is $clog2(NUM_ITER+1) bits. It saturates and does not wrap: it cannot exceed NUM_ITER.
- `abort` has priority over `start` and over all normal transitions. No `done` pulse is produced for an aborted operation.
- `start` while busy is ignored and is not queued.

## Timing
- Outputs are Moore: decoded only from the state register, with no combinational path from inputs.
- Reset values: state IDLE, counter 0, `busy`=0, `done`=0, `load_regN`=0, `load_regD`=0, `sel_ND_mux`=00, `sel_K_mux`=1.
- Latency: with `start` sampled at edge t, INIT_D occupies cycle t+1.
  - Busy cycles: 2 + 2·NUM_ITER, which is 10 for the default.
  - `done` is high in cycle t + 3 + 2·NUM_ITER, which is t+11 for the default.
- Back-to-back: `start` held during DONE gives INIT_D on the very next cycle, with no IDLE gap.
- Reset mid-operation: outputs go to their reset values asynchronously and the datapath registers are not written again. Operation restarts only on a new `start` after `reset` is released.
- Operands (N, D, IA) must be stable from the INIT_D cycle through the INIT_N cycle. The controller does not register them.

## Structure
- Shared package `goldschmidt_pkg`:
  - state enum `gs_state_t`.
  - select constants `SEL_IA_D`=2'b00, `SEL_IA_N`=2'b01, `SEL_K_D`=2'b10, `SEL_K_N`=2'b11.
  - `SEL_K_IA`=1'b1, `SEL_K_FB`=1'b0.
- One sub-module, `gs_iter_counter`: clear, enable, terminal-count flag, parameterized by NUM_ITER.
- The FSM plus output decode form the top level, about 150–250 lines total.

## Test plan
- Reset: hold `reset`=0 for 3 cycles, then release.
  - Required: all outputs at their reset values, `sel_K_mux`=1, state stays IDLE.
- Nominal run, NUM_ITER=4: pulse `start` once.
  - Required `sel_ND_mux`/`sel_K_mux` sequence: 00/1, 01/1, then (10/0, 11/0) ×4.
  - Loads alternate D, N, D, N… across the 10 busy cycles.
  - `done` is high exactly 11 cycles after the start edge.
- Integrated with `datapath`: IA=17'b11000000101000001, N=17'b11101000100001000, D=17'b11111010011011111.
  - Required: on the `done` cycle, `result` is within 2 LSB of 01110110110101110 (≈0.92845).
- Back-to-back: hold `start` high continuously.
  - Required: INIT_D follows DONE directly, giving a `done` pulse every 11 cycles with no IDLE cycle.
- Abort: assert `abort` in the 2nd ITER_D cycle.
  - Required: IDLE on the next edge, no `done` pulse, a new `start` then completes normally.
- Async reset mid-ITER_N: drive `reset`=0 between clock edges.
  - Required: outputs reach reset values before the next edge. With NUM_ITER=1, a full run gives `done` at t+5.

Source files
------------

// File: rtl/goldschmidt_pkg.sv
// Shared types and constants for the Goldschmidt divider controller.
//   gs_state_t : controller state encoding
//   gs_ctrl_t  : registered control word driven onto the datapath
//   gs_decode  : Moore output decode for one state
package goldschmidt_pkg;

    localparam logic [1:0] SEL_IA_D = 2'b00;
    localparam logic [1:0] SEL_IA_N = 2'b01;
    localparam logic [1:0] SEL_K_D  = 2'b10;
    localparam logic [1:0] SEL_K_N  = 2'b11;

    localparam logic SEL_K_IA = 1'b1;
    localparam logic SEL_K_FB = 1'b0;

    typedef enum logic [2:0] {
        GS_IDLE   = 3'd0,
        GS_INIT_D = 3'd1,
        GS_INIT_N = 3'd2,
        GS_ITER_D = 3'd3,
        GS_ITER_N = 3'd4,
        GS_DONE   = 3'd5
    } gs_state_t;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       load_n;
        logic       load_d;
        logic [1:0] sel_nd;
        logic       sel_k;
    } gs_ctrl_t;

    // Control word for a state; IDLE/DONE keep the IA selects parked.
    function automatic gs_ctrl_t gs_decode(input gs_state_t s);
        gs_ctrl_t c;
        c.busy   = 1'b0;
        c.done   = 1'b0;
        c.load_n = 1'b0;
        c.load_d = 1'b0;
        c.sel_nd = SEL_IA_D;
        c.sel_k  = SEL_K_IA;
        case (s)
            GS_INIT_D: begin
                c.busy   = 1'b1;
                c.load_d = 1'b1;
            end
            GS_INIT_N: begin
                c.busy   = 1'b1;
                c.load_n = 1'b1;
                c.sel_nd = SEL_IA_N;
            end
            GS_ITER_D: begin
                c.busy   = 1'b1;
                c.load_d = 1'b1;
                c.sel_nd = SEL_K_D;
                c.sel_k  = SEL_K_FB;
            end
            GS_ITER_N: begin
                c.busy   = 1'b1;
                c.load_n = 1'b1;
                c.sel_nd = SEL_K_N;
                c.sel_k  = SEL_K_FB;
            end
            GS_DONE: c.done = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/gs_iter_counter.sv
// Refinement-pair counter for the Goldschmidt controller.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear to 0 (priority over en)
//   en         : count one completed K pair; saturates at NUM_ITER
//   last_c     : count == NUM_ITER-1, i.e. the current pair is the final one
module gs_iter_counter #(
    parameter int unsigned NUM_ITER = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic last_c
);

    localparam int unsigned CNT_W = $clog2(NUM_ITER + 1);

    logic [CNT_W-1:0] count;

    // Saturating count so a stray enable can never wrap back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != CNT_W'(NUM_ITER))) begin
            count <= count + CNT_W'(1);
        end
    end

    assign last_c = (count == CNT_W'(NUM_ITER - 1));

endmodule

// File: rtl/goldschmidt_ctrl.sv
// Sequencing controller for the Goldschmidt divider datapath.
//   clk, reset  : clock, async active-low reset
//   start       : begin a division (honoured in IDLE and DONE only)
//   abort       : synchronous cancel back to IDLE, highest priority
//   busy        : high INIT_D through the last ITER_N
//   done        : one-cycle pulse while datapath result holds the quotient
//   load_regN/D : datapath register captures (never both high)
//   sel_ND_mux  : operand select (IA*D, IA*N, K*D, K*N)
//   sel_K_mux   : 1 = IA multiplier, 0 = K = 2 - D feedback
module goldschmidt_ctrl
    import goldschmidt_pkg::*;
#(
    parameter int unsigned NUM_ITER = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic       load_regN,
    output logic       load_regD,
    output logic [1:0] sel_ND_mux,
    output logic       sel_K_mux
);

    gs_state_t state;
    gs_state_t state_next;
    gs_ctrl_t  ctrl;
    logic      cnt_clr;
    logic      cnt_en;
    logic      last_c;

    gs_iter_counter #(
        .NUM_ITER (NUM_ITER)
    ) u_iter_counter (
        .clk    (clk),
        .rst_n  (reset),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .last_c (last_c)
    );

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        case (state)
            GS_IDLE:   if (start) state_next = GS_INIT_D;
            GS_INIT_D: state_next = GS_INIT_N;
            GS_INIT_N: begin
                cnt_clr    = 1'b1;
                state_next = GS_ITER_D;
            end
            GS_ITER_D: state_next = GS_ITER_N;
            GS_ITER_N: begin
                cnt_en     = 1'b1;
                state_next = last_c ? GS_DONE : GS_ITER_D;
            end
            GS_DONE:   state_next = start ? GS_INIT_D : GS_IDLE;
            default:   state_next = GS_IDLE;
        endcase
        if (abort) begin
            state_next = GS_IDLE;
        end
    end

    // State register plus the control word registered from the next state,
    // so outputs are glitch-free yet track the current state exactly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= GS_IDLE;
            ctrl  <= gs_decode(GS_IDLE);
        end else begin
            state <= state_next;
            ctrl  <= gs_decode(state_next);
        end
    end

    assign busy       = ctrl.busy;
    assign done       = ctrl.done;
    assign load_regN  = ctrl.load_n;
    assign load_regD  = ctrl.load_d;
    assign sel_ND_mux = ctrl.sel_nd;
    assign sel_K_mux  = ctrl.sel_k;

endmodule

// File: tb/tb_goldschmidt_ctrl.sv
// Directed self-checking bench for goldschmidt_ctrl (NUM_ITER=4 and NUM_ITER=1).
module tb_goldschmidt_ctrl;

    // Output vector {busy, done, load_regN, load_regD, sel_ND_mux[1:0], sel_K_mux}
    localparam logic [6:0] E_IDLE  = 7'b0000001;
    localparam logic [6:0] E_INITD = 7'b1001001;
    localparam logic [6:0] E_INITN = 7'b1010011;
    localparam logic [6:0] E_ITERD = 7'b1001100;
    localparam logic [6:0] E_ITERN = 7'b1010110;
    localparam logic [6:0] E_DONE  = 7'b0100001;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       start1;
    logic       abort;

    logic       busy, done, load_regN, load_regD, sel_K_mux;
    logic [1:0] sel_ND_mux;
    logic       busy1, done1, load_regN1, load_regD1, sel_K_mux1;
    logic [1:0] sel_ND_mux1;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    goldschmidt_ctrl #(.NUM_ITER(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .load_regN  (load_regN),
        .load_regD  (load_regD),
        .sel_ND_mux (sel_ND_mux),
        .sel_K_mux  (sel_K_mux)
    );

    goldschmidt_ctrl #(.NUM_ITER(1)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .start      (start1),
        .abort      (abort),
        .busy       (busy1),
        .done       (done1),
        .load_regN  (load_regN1),
        .load_regD  (load_regD1),
        .sel_ND_mux (sel_ND_mux1),
        .sel_K_mux  (sel_K_mux1)
    );

    function automatic logic [6:0] obs4();
        return {busy, done, load_regN, load_regD, sel_ND_mux, sel_K_mux};
    endfunction

    function automatic logic [6:0] obs1();
        return {busy1, done1, load_regN1, load_regD1, sel_ND_mux1, sel_K_mux1};
    endfunction

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Walk one full NUM_ITER=4 operation starting from the INIT_D cycle.
    task automatic chk_run(input string tag);
        @(negedge clk); chk({tag, " init_d"}, 32'(obs4()), 32'(E_INITD));
        @(negedge clk); chk({tag, " init_n"}, 32'(obs4()), 32'(E_INITN));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); chk($sformatf("%s iter_d%0d", tag, i), 32'(obs4()), 32'(E_ITERD));
            @(negedge clk); chk($sformatf("%s iter_n%0d", tag, i), 32'(obs4()), 32'(E_ITERN));
        end
        @(negedge clk); chk({tag, " done"}, 32'(obs4()), 32'(E_DONE));
    endtask

    int  cycles;
    logic seen_done;

    initial begin
        reset  = 1'b0;
        start  = 1'b0;
        start1 = 1'b0;
        abort  = 1'b0;

        // Reset held for 3 cycles
        repeat (3) @(negedge clk);
        chk("reset_hold", 32'(obs4()), 32'(E_IDLE));
        chk("reset_hold_n1", 32'(obs1()), 32'(E_IDLE));
        reset = 1'b1;
        @(negedge clk);
        chk("after_reset", 32'(obs4()), 32'(E_IDLE));
        @(negedge clk);
        chk("idle_stays", 32'(obs4()), 32'(E_IDLE));

        // Nominal single-pulse run
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("nom init_d", 32'(obs4()), 32'(E_INITD));
        @(negedge clk); chk("nom init_n", 32'(obs4()), 32'(E_INITN));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); chk($sformatf("nom iter_d%0d", i), 32'(obs4()), 32'(E_ITERD));
            @(negedge clk); chk($sformatf("nom iter_n%0d", i), 32'(obs4()), 32'(E_ITERN));
        end
        @(negedge clk); chk("nom done", 32'(obs4()), 32'(E_DONE));
        @(negedge clk); chk("nom idle", 32'(obs4()), 32'(E_IDLE));

        // Latency: done 11 cycles after the start edge
        start = 1'b1;
        cycles = 0;
        seen_done = 1'b0;
        while (!seen_done && cycles < 40) begin
            @(negedge clk);
            start = 1'b0;
            cycles++;
            seen_done = done;
        end
        chk("latency4", 32'(cycles), 32'd11);
        @(negedge clk); chk("latency4 idle", 32'(obs4()), 32'(E_IDLE));

        // Back-to-back with start held
        start = 1'b1;
        chk_run("b2b0");
        chk_run("b2b1");
        start = 1'b0;
        @(negedge clk); chk("b2b idle", 32'(obs4()), 32'(E_IDLE));

        // Start while busy is ignored
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("busy_start iter_d", 32'(obs4()), 32'(E_ITERD));
        for (int i = 0; i < 8; i++) @(negedge clk);
        chk("busy_start done", 32'(obs4()), 32'(E_DONE));
        @(negedge clk); chk("busy_start idle", 32'(obs4()), 32'(E_IDLE));

        // Abort in the second ITER_D
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); chk("abort at iter_d2", 32'(obs4()), 32'(E_ITERD));
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("abort idle", 32'(obs4()), 32'(E_IDLE));
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        chk("abort no_done", 32'(seen_done), 32'd0);
        start = 1'b1;
        cycles = 0;
        seen_done = 1'b0;
        while (!seen_done && cycles < 40) begin
            @(negedge clk);
            start = 1'b0;
            cycles++;
            seen_done = done;
        end
        chk("abort restart latency", 32'(cycles), 32'd11);
        @(negedge clk);

        // Async reset mid ITER_N, between edges
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); chk("pre_reset iter_n", 32'(obs4()), 32'(E_ITERN));
        #2 reset = 1'b0;
        #1 chk("async reset", 32'(obs4()), 32'(E_IDLE));
        @(negedge clk); chk("reset held", 32'(obs4()), 32'(E_IDLE));
        reset = 1'b1;
        @(negedge clk); chk("post_reset idle", 32'(obs4()), 32'(E_IDLE));
        @(negedge clk); chk("post_reset idle2", 32'(obs4()), 32'(E_IDLE));

        // NUM_ITER=1 full run: done at t+5
        start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        chk("n1 init_d", 32'(obs1()), 32'(E_INITD));
        @(negedge clk); chk("n1 init_n", 32'(obs1()), 32'(E_INITN));
        @(negedge clk); chk("n1 iter_d", 32'(obs1()), 32'(E_ITERD));
        @(negedge clk); chk("n1 iter_n", 32'(obs1()), 32'(E_ITERN));
        @(negedge clk); chk("n1 done", 32'(obs1()), 32'(E_DONE));
        @(negedge clk); chk("n1 idle", 32'(obs1()), 32'(E_IDLE));
        chk("n1 other idle", 32'(obs4()), 32'(E_IDLE));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
